// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared types and defaults for the shift-add multiplier.
// The FSM state encoding lives here so the top and any future siblings agree on it.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MULT_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Request/response bundle of the multiplier. The master issues operands;
// the slave (the multiplier) reports its state and the product.
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = mult_pkg::MULT_WIDTH_DEFAULT
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               ready;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (output start, a, b, input ready, busy, done, product);
  modport slave  (input start, a, b, output ready, busy, done, product);
endinterface

// File: rtl/seq_shift_add_multiplier_adder.sv
// Level-1 arithmetic: a full-adder cell and a WIDTH-bit ripple chain of them.
// The chain is an array of instances, with the carries threaded through w_c.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module nbit_ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  logic [WIDTH:0] w_c;

  assign w_c[0] = i_cin;

  full_adder u_fa [WIDTH-1:0] (
    .i_a   (i_a),
    .i_b   (i_b),
    .i_cin (w_c[WIDTH-1:0]),
    .o_sum (o_sum),
    .o_cout(w_c[WIDTH:1])
  );

  assign o_cout = w_c[WIDTH];
endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier: one partial product per clock,
// WIDTH+1 clocks from accept to done. Outputs are decoded from state or registered.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  seq_shift_add_multiplier_if.slave   bus
);
  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  mult_state_t        r_state;
  mult_state_t        w_next;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_last;

  // Upper half accumulates; the multiplier bit under test always sits in acc[0].
  assign w_addend  = r_acc[0] ? r_mcand : '0;
  assign w_acc_nxt = {w_cout, w_sum, r_acc[WIDTH-1:1]};
  assign w_last    = (r_cnt == LAST);

  nbit_ripple_adder #(.WIDTH(WIDTH)) u_add (
    .i_a   (r_acc[2*WIDTH-1:WIDTH]),
    .i_b   (w_addend),
    .i_cin (1'b0),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ready   = (r_state == IDLE);
    bus.busy    = (r_state == RUN);
    bus.done    = (r_state == DONE);
    bus.product = r_product;
  end

  // Product is captured on the final add/shift and is never cleared by a new start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (bus.start) begin
          r_mcand <= bus.a;
          r_acc   <= {{WIDTH{1'b0}}, bus.b};
          r_cnt   <= '0;
        end
        RUN: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_product <= w_acc_nxt;
        end
        default: ;
      endcase
    end
  end
endmodule
